mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath: control FSM plus PC-update logic.
- Replaces single-cycle decode with a Moore FSM so one memory and one ALU serve fetch, address calculation and PC increment.
- Sits beside the register bank, ALU control and memory; drives mux selects, write strobes and PC enable.
- Supports memory wait states via `mem_ready`; halts on illegal opcode.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register (IR)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR (memory data register)
- reg_write  out  1  register bank write strobe
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left by 2
- alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct
- state  out  4  current state, for debug
- halted  out  1  illegal opcode trapped
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - state = FETCH, instr_count = 0, halted = 0.
  - While rst=1, pc_en, ir_write, reg_write and mem_write are forced to 0.
  - The remaining outputs show FETCH decode: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; all other outputs 0.
  - Reset mid-instruction aborts it with no further writes.
- Outputs are a combinational function of state only, except ir_write and pc_en.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- State encoding and transitions (unlisted outputs are 0):
  - FETCH (0): mem_read, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_en equal mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode: LW/SW→MEM_ADDR, R→R_EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDI_EXEC, any other opcode→HALT.
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ if LW, MEM_WRITE if SW.
  - MEM_READ (3): mem_read, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
  - MEM_WB (4): reg_write, mem_to_reg=1, reg_dst=0. Retires; goes to FETCH.
  - MEM_WRITE (5): mem_write, i_or_d=1. Waits for mem_ready; retires on the mem_ready cycle; goes to FETCH.
  - R_EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
  - R_WB (7): reg_write, reg_dst=1, mem_to_reg=0. Retires; goes to FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero. Retires; goes to FETCH.
  - JUMP (9): pc_source=10, pc_en=1. Retires; goes to FETCH.
  - ADDI_EXEC (10): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
  - ADDI_WB (11): reg_write, reg_dst=0, mem_to_reg=0. Retires; goes to FETCH.
  - HALT (12): halted=1, all strobes 0. Exited only by reset.
  - Codes 13–15 are unreachable; if entered, go to HALT.
- Waits: mem_write stays asserted for every cycle MEM_WRITE waits; the memory writes exactly once, on the mem_ready cycle.
- Retire: instr_count increments by 1 on the retire cycle and wraps modulo 2^CNT_W. A retire and a reset in the same cycle leave the count at 0.
- Latency (mem_ready tied to 1):
  - LW: 5 cycles.
  - SW, R-type, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each waited cycle adds 1.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state encodings
  - opcode constants
  - alu_op, pc_source and alu_src_b codes
- Sub-module mips_ctrl_decode: combinational state → control word.
- The top level holds the state register, next-state logic, pc_en/ir_write gating, counter and reset gating.

Test Plan:
- Reset then release with mem_ready=1, opcode=000000 → state sequence 0,1,6,7,0; reg_write=1 only in state 7, with reg_dst=1; instr_count=1.
- LW (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ → total 10 cycles; ir_write pulses once; reg_write once with mem_to_reg=1; count +1.
- BEQ with zero=1, then BEQ with zero=0 → pc_en=1 with pc_source=01 in state 8 for the first, pc_en=0 for the second; each takes 3 cycles.
- SW (101011) with mem_ready low for 2 cycles in MEM_WRITE → mem_write high for 3 cycles; reg_write never asserted; state returns to 0.
- opcode=111111 → HALT after DECODE; halted=1 and all strobes 0 for 20 cycles; only reset restores FETCH with count=0.
- rst asserted during R_EXEC → state immediately 0; reg_write never pulses; instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// datapath select codes and the decoded control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StHalt     = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBRt     = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  typedef struct packed {
    logic       fetch;         // ir_write/pc_en follow mem_ready
    logic       pc_write;      // unconditional PC load
    logic       pc_write_cond; // PC load when ALU zero
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: maps the current FSM state to the datapath control word.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.fetch     = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = AluOpAdd;
        ctrl_o.pc_source = PcSrcAlu;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SrcBImmSh2;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemAddr, StAddiExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      StRExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBRt;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StRWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBRt;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_source     = PcSrcAluOut;
        ctrl_o.pc_write_cond = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_source = PcSrcJump;
        ctrl_o.pc_write  = 1'b1;
      end
      StAddiWb: ctrl_o.reg_write = 1'b1;
      StHalt:   ctrl_o.halted    = 1'b1;
      default:  ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, next-state logic, PC/IR write
// gating, reset strobe gating and the retired-instruction counter.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  ctrl_t            ctrl;

  mips_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRType:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default:    state_d = StHalt;
        endcase
      end
      StMemAddr: begin
        if (opcode == OpLw)      state_d = StMemRead;
        else if (opcode == OpSw) state_d = StMemWrite;
        else                     state_d = StHalt;
      end
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWrite: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StMemWb, StRWb, StBranch, StJump, StAddiWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      StHalt:     state_d = StHalt;
      default:    state_d = StHalt;
    endcase
  end

  assign count_d = retire ? count_q + 1'b1 : count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Write strobes are masked while rst is high so an aborted instruction cannot commit.
  assign pc_en       = ~rst & ((ctrl.fetch & mem_ready) | ctrl.pc_write
                               | (ctrl.pc_write_cond & zero));
  assign ir_write    = ~rst & ctrl.fetch & mem_ready;
  assign reg_write   = ~rst & ctrl.reg_write;
  assign mem_write   = ~rst & ctrl.mem_write;
  assign pc_source   = ctrl.pc_source;
  assign i_or_d      = ctrl.i_or_d;
  assign mem_read    = ctrl.mem_read;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign halted      = ctrl.halted;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
